// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: N_CH independent counters with prescaler, compare,
// one-shot, hardware start event and sticky W1C interrupt pending flags.

module apb_timer_ch #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_wr_cfg,
    input  logic        i_wr_val,
    input  logic        i_wr_cmp,
    input  logic        i_wr_stat,
    input  logic [31:0] i_wdata,
    input  logic        i_event,
    output logic [31:0] o_cfg,
    output logic [31:0] o_val,
    output logic [31:0] o_cmp,
    output logic        o_pend,
    output logic        o_irq
);
    logic                 r_en, r_irq_en, r_cmp_clr, r_one_shot, r_presc_en, r_pend;
    logic [7:0]           r_presc, r_pcnt;
    logic [CNT_WIDTH-1:0] r_val, r_cmp;
    logic                 w_tick, w_match, w_start, w_unused;

    assign w_tick   = r_en & (~r_presc_en | (r_pcnt == r_presc));
    assign w_match  = w_tick & (r_val == r_cmp);
    // Start is an EN rising edge; it resets the count and suppresses the tick.
    assign w_start  = ~r_en & (i_event | (i_wr_cfg & i_wdata[0]));
    assign w_unused = ^i_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_cmp_clr  <= 1'b0;
            r_one_shot <= 1'b0;
            r_presc_en <= 1'b0;
            r_presc    <= '0;
            r_pcnt     <= '0;
            r_val      <= '0;
            r_cmp      <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (i_wr_cfg) begin
                r_irq_en   <= i_wdata[1];
                r_cmp_clr  <= i_wdata[2];
                r_one_shot <= i_wdata[3];
                r_presc_en <= i_wdata[4];
                r_presc    <= i_wdata[15:8];
            end
            // Event beats a CFG write, which beats the one-shot clear.
            if (i_event)                     r_en <= 1'b1;
            else if (i_wr_cfg)               r_en <= i_wdata[0];
            else if (w_match && r_one_shot)  r_en <= 1'b0;

            if (i_wr_val)     r_val <= i_wdata[CNT_WIDTH-1:0];
            else if (w_start) r_val <= '0;
            else if (w_tick)  r_val <= (w_match && r_cmp_clr) ? '0 : r_val + CNT_WIDTH'(1);

            if (i_wr_cmp) r_cmp <= i_wdata[CNT_WIDTH-1:0];

            if (w_start)                  r_pcnt <= '0;
            else if (r_en && r_presc_en)  r_pcnt <= (r_pcnt == r_presc) ? 8'd0 : r_pcnt + 8'd1;

            if (w_match)                     r_pend <= 1'b1;
            else if (i_wr_stat && i_wdata[0]) r_pend <= 1'b0;
        end
    end

    assign o_cfg  = {16'd0, r_presc, 3'd0, r_presc_en, r_one_shot, r_cmp_clr, r_irq_en, r_en};
    assign o_val  = 32'(r_val);
    assign o_cmp  = 32'(r_cmp);
    assign o_pend = r_pend;
    assign o_irq  = r_pend & r_irq_en;
endmodule

module apb_timer_multi #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int N_CH           = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
    input  logic [31:0]               PWDATA_i,
    input  logic                      PWRITE_i,
    input  logic                      PSEL_i,
    input  logic                      PENABLE_i,
    output logic [31:0]               PRDATA_o,
    output logic                      PREADY_o,
    output logic                      PSLVERR_o,
    input  logic [N_CH-1:0]           event_i,
    output logic [N_CH-1:0]           irq_o
);
    logic                       w_access, w_ch_ok, w_unused;
    logic [2:0]                 w_ch;
    logic [1:0]                 w_off;
    logic [N_CH-1:0][31:0]      w_cfg, w_val, w_cmp, w_rword;
    logic [N_CH-1:0]            w_pend;

    assign w_access  = PSEL_i & PENABLE_i;
    assign w_ch      = PADDR_i[6:4];
    assign w_off     = PADDR_i[3:2];
    assign w_ch_ok   = int'(w_ch) < N_CH;
    assign w_unused  = ^PADDR_i;
    assign PREADY_o  = 1'b1;
    assign PSLVERR_o = w_access & ~w_ch_ok;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic w_wr;
        assign w_wr = w_access & PWRITE_i & (w_ch == 3'(i));

        apb_timer_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_wr_cfg  (w_wr & (w_off == 2'd0)),
            .i_wr_val  (w_wr & (w_off == 2'd1)),
            .i_wr_cmp  (w_wr & (w_off == 2'd2)),
            .i_wr_stat (w_wr & (w_off == 2'd3)),
            .i_wdata   (PWDATA_i),
            .i_event   (event_i[i]),
            .o_cfg     (w_cfg[i]),
            .o_val     (w_val[i]),
            .o_cmp     (w_cmp[i]),
            .o_pend    (w_pend[i]),
            .o_irq     (irq_o[i])
        );

        always_comb begin
            case (w_off)
                2'd0:    w_rword[i] = w_cfg[i];
                2'd1:    w_rword[i] = w_val[i];
                2'd2:    w_rword[i] = w_cmp[i];
                default: w_rword[i] = {31'd0, w_pend[i]};
            endcase
        end
    end

    always_comb begin
        PRDATA_o = 32'd0;
        if (w_access && !PWRITE_i) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_ch == 3'(i)) PRDATA_o = w_rword[i];
            end
        end
    end
endmodule
